apb_master_asynch_arb: RTL and testbench
========================================

Name: apb_master_asynch_arb

Overview:
Source-domain side of the APB CDC. It arbitrates NB_MASTERS local APB masters round-robin onto a single 4-phase asynchronous req/ack channel (req↑ → ack↑ → req↓ → ack↓). The channel feeds the destination-domain APB slave bridge. The block owns the request flop, the ack synchronizer and the response capture, and returns PREADY/PRDATA/PSLVERR to the granted master.

Parameters:
NB_MASTERS, 2, number of local APB masters (≥1)
APB_ADDR_WIDTH, 32, address width
APB_DATA_WIDTH, 32, data width

Ports:
clk  in  1  source-domain clock
rst_n  in  1  asynchronous active-low reset
PADDR_i  in  NB_MASTERS×APB_ADDR_WIDTH  per-master address
PWDATA_i  in  NB_MASTERS×APB_DATA_WIDTH  per-master write data
PWRITE_i  in  NB_MASTERS  per-master write flag
PSEL_i  in  NB_MASTERS  per-master select
PENABLE_i  in  NB_MASTERS  per-master enable
PRDATA_o  out  APB_DATA_WIDTH  shared read data, valid only with a PREADY_o bit
PREADY_o  out  NB_MASTERS  one-hot completion pulse
PSLVERR_o  out  NB_MASTERS  error, qualified by PREADY_o
asynch_req_o  out  1  4-phase request, driven directly from a flop
asynch_ack_i  in  1  4-phase ack from the destination domain
async_PADDR_o  out  APB_ADDR_WIDTH  registered address toward the channel
async_PWDATA_o  out  APB_DATA_WIDTH  registered write data
async_PWRITE_o  out  1  registered write flag
async_PSEL_o  out  1  registered select (1 for every issued transfer)
async_PRDATA_i  in  APB_DATA_WIDTH  response data, stable while ack high
async_PSLVERR_i  in  1  response error, stable while ack high

Behaviour:
- Clock/reset: one clock `clk`; reset `rst_n` is asynchronous, active-low.
- Reset values: all outputs 0, FSM in IDLE, ack synchronizer 00, RR pointer = NB_MASTERS-1 (master 0 wins first).
- asynch_ack_i passes a 2-flop synchronizer (ack_s). No other async input is synchronized; those are sampled only while ack_s=1.
- Pending[k] = PSEL_i[k] & PENABLE_i[k]. Masters hold their signals until PREADY_o[k].
- Grant: round-robin. Search starts at pointer+1 and wraps modulo NB_MASTERS. The pointer updates to the granted index on the IDLE→REQ_UP transition.

FSM states (encoding lives in the package):
- IDLE: if any Pending and ack_s=0, then grant, latch async_PADDR/PWDATA/PWRITE from the winner, set async_PSEL_o=1, store grant index, → REQ_UP. If ack_s=1 (stale ack after reset), stay in IDLE.
- REQ_UP: asynch_req_o=1. Data is already stable one cycle before req rises. When ack_s=1, capture async_PRDATA_i/async_PSLVERR_i into local regs, → REQ_DOWN.
- REQ_DOWN: asynch_req_o=0, async_PSEL_o=0. When ack_s=0 → RESP.
- RESP: PREADY_o[grant]=1 for exactly one cycle, PRDATA_o = captured data, PSLVERR_o[grant] = captured error, → IDLE.

Timing and datapath rules:
- Minimum latency, grant to PREADY: 1 (req rises) + dest round trip + 2 sync cycles ack↑ + 2 sync cycles ack↓ + 1.
- Outside RESP: PREADY_o=0, PSLVERR_o=0, PRDATA_o holds its last value.
- At most one outstanding transfer. A new transfer starts no earlier than the cycle after RESP.

Boundary conditions:
- Simultaneous requests: exactly one granted per RR order. Requests arriving during a transfer wait.
- Master drops PSEL mid-transfer (protocol violation): the handshake still completes and the PREADY pulse is issued and ignored; no hang.
- NB_MASTERS=1: arbiter degenerates to pass-through of the single request.
- Reset mid-transfer: everything returns to reset values and req drops immediately. No new request is issued until ack_s has been observed 0.

Decomposition:
- Package apb_cdc_pkg: FSM state enum (IDLE, REQ_UP, REQ_DOWN, RESP), 4-phase protocol comment constants.
- Sub-module apb_cdc_rr_arbiter: combinational RR pick from (pending vector, pointer), producing grant one-hot, grant index and valid.
- The top level holds the FSM, registers and synchronizer.

Test Plan:
- Single write: master 0 writes PADDR=0x1000_0040, PWDATA=0xDEAD_BEEF; dest acks after 3 cycles → async_PADDR_o/PWDATA_o stable before req↑, PREADY_o=01 once, PSLVERR_o=0.
- Read with error: master 1 reads; dest returns PRDATA=0x1234_5678, PSLVERR=1 → PRDATA_o=0x1234_5678, PSLVERR_o=10 coincident with PREADY_o=10.
- Contention: masters 0 and 1 request continuously for 4 transfers → grant order 0,1,0,1; never two PREADY bits set.
- Handshake ordering: a random ack delay of 0–20 cycles on each edge → req never rises while ack_s=1; req falls only after ack_s=1; 100 transfers complete without deadlock.
- Reset mid-transfer: assert rst_n low in REQ_UP with ack held high → outputs 0; after reset no req↑ until ack is released, then a pending transfer completes normally.
- Protocol violation: master drops PSEL in REQ_DOWN → PREADY pulse still issued, FSM returns to IDLE, next master is served.

Source files
------------

// File: rtl/apb_cdc_pkg.sv
// Shared definitions for the source-domain side of the APB clock-domain crossing.
// Holds the master FSM states and the constants of the 4-phase req/ack channel.
package apb_cdc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ_UP   = 2'd1,
    ST_REQ_DOWN = 2'd2,
    ST_RESP     = 2'd3
  } state_e;

  // 4-phase channel: req rises, ack rises, req falls, ack falls
  localparam int HS_PHASES       = 4;
  localparam int ACK_SYNC_STAGES = 2;

endpackage

// File: rtl/apb_cdc_rr_arbiter.sv
// Combinational round-robin pick: search starts one past the last winner and
// wraps modulo NB_MASTERS.
module apb_cdc_rr_arbiter #(
  parameter int NB_MASTERS = 2,
  parameter int IDX_W      = 1
) (
  input  logic [NB_MASTERS-1:0] pending,
  input  logic [IDX_W-1:0]      ptr,
  output logic [NB_MASTERS-1:0] gnt,
  output logic [IDX_W-1:0]      gnt_idx,
  output logic                  gnt_vld
);

  always_comb begin
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    gnt      = '0;
    gnt_idx  = '0;
    gnt_vld  = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int i = 1; i <= NB_MASTERS; i++) begin
      cand     = (int'(ptr) + i) % NB_MASTERS;
      cand_idx = IDX_W'(cand);
      if (!gnt_vld && pending[cand_idx]) begin
        gnt_vld       = 1'b1;
        gnt[cand_idx] = 1'b1;
        gnt_idx       = cand_idx;
      end
    end
  end

endmodule

// File: rtl/apb_master_asynch_arb.sv
// Source-domain APB CDC master: round-robin arbitration of local APB masters onto
// one 4-phase asynchronous req/ack channel, with response return to the winner.
module apb_master_asynch_arb
  import apb_cdc_pkg::*;
#(
  parameter int NB_MASTERS     = 2,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NB_MASTERS*APB_ADDR_WIDTH-1:0] PADDR_i,
  input  logic [NB_MASTERS*APB_DATA_WIDTH-1:0] PWDATA_i,
  input  logic [NB_MASTERS-1:0]                PWRITE_i,
  input  logic [NB_MASTERS-1:0]                PSEL_i,
  input  logic [NB_MASTERS-1:0]                PENABLE_i,
  output logic [APB_DATA_WIDTH-1:0]            PRDATA_o,
  output logic [NB_MASTERS-1:0]                PREADY_o,
  output logic [NB_MASTERS-1:0]                PSLVERR_o,
  output logic                                 asynch_req_o,
  input  logic                                 asynch_ack_i,
  output logic [APB_ADDR_WIDTH-1:0]            async_PADDR_o,
  output logic [APB_DATA_WIDTH-1:0]            async_PWDATA_o,
  output logic                                 async_PWRITE_o,
  output logic                                 async_PSEL_o,
  input  logic [APB_DATA_WIDTH-1:0]            async_PRDATA_i,
  input  logic                                 async_PSLVERR_i
);

  localparam int IDX_W = (NB_MASTERS > 1) ? $clog2(NB_MASTERS) : 1;

  state_e                    state;
  logic                      ack_p0, ack_p1;
  logic                      prime_p0, prime_p1;
  logic [IDX_W-1:0]          rr_ptr, gnt_idx_q, win_idx;
  logic [NB_MASTERS-1:0]     pending, win_onehot, gnt_onehot;
  logic                      win_vld;
  logic [APB_ADDR_WIDTH-1:0] win_addr;
  logic [APB_DATA_WIDTH-1:0] win_wdata;
  logic                      win_write;
  logic [APB_DATA_WIDTH-1:0] rdata_cap;
  logic                      err_cap;
  logic                      cap_en;

  assign pending    = PSEL_i & PENABLE_i;
  assign gnt_onehot = NB_MASTERS'(1) << gnt_idx_q;
  assign cap_en     = (state == ST_REQ_UP) && asynch_req_o && ack_p1;

  apb_cdc_rr_arbiter #(
    .NB_MASTERS(NB_MASTERS),
    .IDX_W     (IDX_W)
  ) u_arb (
    .pending(pending),
    .ptr    (rr_ptr),
    .gnt    (win_onehot),
    .gnt_idx(win_idx),
    .gnt_vld(win_vld)
  );

  always_comb begin
    win_addr  = '0;
    win_wdata = '0;
    win_write = 1'b0;
    for (int k = 0; k < NB_MASTERS; k++) begin
      if (win_onehot[k]) begin
        win_addr  = PADDR_i[k*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
        win_wdata = PWDATA_i[k*APB_DATA_WIDTH +: APB_DATA_WIDTH];
        win_write = PWRITE_i[k];
      end
    end
  end

  // Stage p0/p1: ack synchronizer; prime_p1 marks that ack_p1 holds a post-reset sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_p0   <= 1'b0;
      ack_p1   <= 1'b0;
      prime_p0 <= 1'b0;
      prime_p1 <= 1'b0;
    end else begin
      ack_p0   <= asynch_ack_i;
      ack_p1   <= ack_p0;
      prime_p0 <= 1'b1;
      prime_p1 <= prime_p0;
    end
  end

  // Response is stable while ack is high, so it is sampled once ack_p1 has seen it
  always_ff @(posedge clk) begin
    if (cap_en) begin
      rdata_cap <= async_PRDATA_i;
      err_cap   <= async_PSLVERR_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      rr_ptr         <= IDX_W'(NB_MASTERS - 1);
      gnt_idx_q      <= '0;
      asynch_req_o   <= 1'b0;
      async_PSEL_o   <= 1'b0;
      async_PADDR_o  <= '0;
      async_PWDATA_o <= '0;
      async_PWRITE_o <= 1'b0;
      PRDATA_o       <= '0;
      PREADY_o       <= '0;
      PSLVERR_o      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (win_vld && prime_p1 && !ack_p1) begin
            async_PADDR_o  <= win_addr;
            async_PWDATA_o <= win_wdata;
            async_PWRITE_o <= win_write;
            async_PSEL_o   <= 1'b1;
            gnt_idx_q      <= win_idx;
            rr_ptr         <= win_idx;
            state          <= ST_REQ_UP;
          end
        end
        ST_REQ_UP: begin
          // req rises one cycle after the channel data was latched
          asynch_req_o <= 1'b1;
          if (asynch_req_o && ack_p1) begin
            asynch_req_o <= 1'b0;
            async_PSEL_o <= 1'b0;
            state        <= ST_REQ_DOWN;
          end
        end
        ST_REQ_DOWN: begin
          if (!ack_p1) begin
            PREADY_o  <= gnt_onehot;
            PSLVERR_o <= err_cap ? gnt_onehot : '0;
            PRDATA_o  <= rdata_cap;
            state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          PREADY_o  <= '0;
          PSLVERR_o <= '0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_asynch_arb.sv
// Bench for apb_master_asynch_arb: two local masters, a destination responder with
// programmable ack delays, and a round-robin reference for grant order.
module tb_apb_master_asynch_arb;

  localparam int NM = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n;

  logic [AW-1:0] m_addr  [NM];
  logic [DW-1:0] m_wdata [NM];
  logic [NM-1:0] m_write, m_sel, m_en;

  logic [NM*AW-1:0] paddr;
  logic [NM*DW-1:0] pwdata;
  logic [DW-1:0]    prdata;
  logic [NM-1:0]    pready, pslverr;
  logic             req, ack;
  logic [AW-1:0]    a_addr;
  logic [DW-1:0]    a_wdata;
  logic             a_write, a_psel;
  logic [DW-1:0]    resp_data;
  logic             resp_err;

  logic ack_auto = 1'b0, ack_man = 1'b0, dest_auto = 1'b1;
  int   dly_up = 0, dly_dn = 0, rec_cnt = 0, dest_to = 0;
  logic [AW-1:0] rec_addr;
  logic [DW-1:0] rec_wdata;
  logic          rec_write, rec_psel;

  int tests = 0, fails = 0;
  int m_ptr = NM - 1;
  int rec_exp = 0;

  assign paddr  = {m_addr[1], m_addr[0]};
  assign pwdata = {m_wdata[1], m_wdata[0]};
  assign ack    = dest_auto ? ack_auto : ack_man;

  apb_master_asynch_arb #(
    .NB_MASTERS    (NM),
    .APB_ADDR_WIDTH(AW),
    .APB_DATA_WIDTH(DW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .PADDR_i        (paddr),
    .PWDATA_i       (pwdata),
    .PWRITE_i       (m_write),
    .PSEL_i         (m_sel),
    .PENABLE_i      (m_en),
    .PRDATA_o       (prdata),
    .PREADY_o       (pready),
    .PSLVERR_o      (pslverr),
    .asynch_req_o   (req),
    .asynch_ack_i   (ack),
    .async_PADDR_o  (a_addr),
    .async_PWDATA_o (a_wdata),
    .async_PWRITE_o (a_write),
    .async_PSEL_o   (a_psel),
    .async_PRDATA_i (resp_data),
    .async_PSLVERR_i(resp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Destination domain: records the request, acks after dly_up, releases after dly_dn
  initial begin
    forever begin
      @(negedge clk);
      if (dest_auto && rst_n && req && !ack) begin
        rec_addr  = a_addr;
        rec_wdata = a_wdata;
        rec_write = a_write;
        rec_psel  = a_psel;
        rec_cnt++;
        repeat (dly_up) @(negedge clk);
        ack_auto = 1'b1;
        for (int t = 0; t < 300 && req; t++) @(negedge clk);
        if (req) dest_to++;
        repeat (dly_dn) @(negedge clk);
        ack_auto = 1'b0;
      end
    end
  end

  // Protocol monitor on the channel and the master-side outputs
  logic [1:0]    ack_hist;
  logic          req_prev, psel_prev;
  logic [AW-1:0] addr_prev;
  logic [DW-1:0] prdata_prev;
  logic [NM-1:0] pready_prev;
  int hs_viol = 0, out_viol = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      ack_hist    <= '0;
      req_prev    <= 1'b0;
      psel_prev   <= 1'b0;
      addr_prev   <= '0;
      prdata_prev <= '0;
      pready_prev <= '0;
    end else begin
      if (req && !req_prev && (ack_hist != 2'b00 || !psel_prev || a_addr !== addr_prev))
        hs_viol <= hs_viol + 1;
      if (!req && req_prev && ack_hist != 2'b11)
        hs_viol <= hs_viol + 1;
      if ($countones(pready) > 1 || (pslverr & ~pready) != '0 ||
          (pready != '0 && pready_prev != '0) || (pready == '0 && prdata !== prdata_prev))
        out_viol <= out_viol + 1;
      ack_hist    <= {ack_hist[0], ack};
      req_prev    <= req;
      psel_prev   <= a_psel;
      addr_prev   <= a_addr;
      prdata_prev <= prdata;
      pready_prev <= pready;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Round-robin rule: first pending master after the last winner, wrapping around
  function automatic int pick(input logic [NM-1:0] pend, input int ptr);
    for (int i = 1; i <= NM; i++) begin
      if (pend[(ptr + i) % NM]) return (ptr + i) % NM;
    end
    return -1;
  endfunction

  task automatic start(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic w);
    m_addr[k]  = a;
    m_wdata[k] = d;
    m_write[k] = w;
    m_sel[k]   = 1'b1;
    m_en[k]    = 1'b1;
  endtask

  task automatic start_rand(input int k);
    start(k, $urandom, $urandom, 1'($urandom_range(0, 1)));
  endtask

  task automatic set_resp();
    resp_data = $urandom;
    resp_err  = 1'($urandom_range(0, 1));
    dly_up    = $urandom_range(0, 20);
    dly_dn    = $urandom_range(0, 20);
  endtask

  task automatic serve(input string tag, input int w, output int got);
    logic [NM-1:0] pr;
    logic [NM-1:0] pr_exp;
    int n;
    pr = '0;
    n  = 0;
    while (pr === '0 && n < 500) begin
      @(negedge clk);
      pr = pready;
      n++;
    end
    pr_exp = NM'(1) << w;
    got = -1;
    for (int k = 0; k < NM; k++) if (pr[k]) got = k;
    check({tag, "_done"}, 64'(pr !== '0), 64'(1));
    check({tag, "_pready"}, pr, pr_exp);
    check({tag, "_pslverr"}, pslverr, resp_err ? pr_exp : '0);
    check({tag, "_prdata"}, prdata, resp_data);
    rec_exp++;
    check({tag, "_nreq"}, rec_cnt, rec_exp);
    check({tag, "_addr"}, rec_addr, m_addr[w]);
    check({tag, "_wdata"}, rec_wdata, m_wdata[w]);
    check({tag, "_write"}, rec_write, m_write[w]);
    check({tag, "_psel"}, rec_psel, 1'b1);
    m_ptr    = w;
    m_sel[w] = 1'b0;
    m_en[w]  = 1'b0;
  endtask

  task automatic wait_req(input logic lvl, input string tag);
    int n;
    n = 0;
    while (req !== lvl && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, req, lvl);
  endtask

  initial begin
    int got;
    int exp_seq[4];
    int req_hi;
    exp_seq = '{0, 1, 0, 1};
    rst_n     = 1'b0;
    m_sel     = '0;
    m_en      = '0;
    m_write   = '0;
    resp_data = '0;
    resp_err  = 1'b0;
    for (int k = 0; k < NM; k++) begin
      m_addr[k]  = '0;
      m_wdata[k] = '0;
    end

    repeat (3) @(negedge clk);
    check("rst_req", req, 1'b0);
    check("rst_pready", pready, '0);
    check("rst_pslverr", pslverr, '0);
    check("rst_prdata", prdata, '0);
    check("rst_psel", a_psel, 1'b0);
    check("rst_paddr", a_addr, '0);
    rst_n = 1'b1;

    // Single write from master 0
    dly_up = 3; dly_dn = 3; resp_data = '0; resp_err = 1'b0;
    start(0, 32'h1000_0040, 32'hDEAD_BEEF, 1'b1);
    serve("wr0", pick(m_sel & m_en, m_ptr), got);

    // Read with error from master 1
    resp_data = 32'h1234_5678; resp_err = 1'b1;
    start(1, 32'h2000_0008, 32'h0, 1'b0);
    serve("rd1", pick(m_sel & m_en, m_ptr), got);

    // Contention: both masters keep requesting
    start_rand(0);
    start_rand(1);
    for (int i = 0; i < 4; i++) begin
      set_resp();
      serve("cont", pick(m_sel & m_en, m_ptr), got);
      check("cont_order", got, exp_seq[i]);
      if (i < 3) start_rand(got);
      set_resp();
    end

    // Randomized traffic with random ack delays on each edge
    for (int it = 0; it < 100; it++) begin
      set_resp();
      for (int k = 0; k < NM; k++) if (!m_sel[k] && $urandom_range(0, 1) == 1) start_rand(k);
      if (m_sel == '0) start_rand($urandom_range(0, NM - 1));
      serve("rnd", pick(m_sel & m_en, m_ptr), got);
    end
    while (m_sel != '0) begin
      set_resp();
      serve("drain", pick(m_sel & m_en, m_ptr), got);
    end

    // Protocol violation: master 0 drops its select while the channel is in REQ_DOWN
    dly_up = 2; dly_dn = 6; resp_data = $urandom; resp_err = 1'b0;
    start_rand(0);
    wait_req(1'b1, "viol_req_up");
    wait_req(1'b0, "viol_req_down");
    got = pick(m_sel & m_en, m_ptr);
    m_sel[0] = 1'b0;
    m_en[0]  = 1'b0;
    start_rand(1);
    serve("viol", got, got);
    set_resp();
    serve("viol_next", pick(m_sel & m_en, m_ptr), got);
    check("viol_next_idx", got, 1);

    // Reset while REQ_UP with ack held high
    dest_auto = 1'b0;
    ack_man   = 1'b0;
    resp_data = 32'hA5A5_0001; resp_err = 1'b0; dly_up = 1; dly_dn = 1;
    start_rand(0);
    wait_req(1'b1, "rstmid_req_up");
    ack_man = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rstmid_req", req, 1'b0);
    check("rstmid_psel", a_psel, 1'b0);
    check("rstmid_paddr", a_addr, '0);
    check("rstmid_pready", pready, '0);
    check("rstmid_prdata", prdata, '0);
    @(negedge clk);
    rst_n  = 1'b1;
    m_ptr  = NM - 1;
    req_hi = 0;
    repeat (12) begin
      @(negedge clk);
      if (req) req_hi++;
    end
    check("rstmid_no_req_stale_ack", req_hi, 0);
    dest_auto = 1'b1;
    serve("rst_resume", pick(m_sel & m_en, m_ptr), got);
    check("rst_resume_idx", got, 0);

    repeat (5) @(negedge clk);
    check("handshake_order", hs_viol, 0);
    check("output_rules", out_viol, 0);
    check("dest_timeout", dest_to, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
